// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell time-shared over WIDTH clocks,
// LSB first, with a start/busy/done handshake and a held, registered result.
`timescale 1ns/1ps

module serial_add_fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] ar, br, acc, acc_nxt;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             s, co;

   serial_add_fa u_fa (
      .x  (ar[0]),
      .y  (br[0]),
      .ci (c),
      .s  (s),
      .co (co)
   );

   // Each new sum bit enters at the MSB so the LSB-first stream lands aligned.
   generate
      if (WIDTH == 1) begin : g_acc1
         assign acc_nxt = s;
      end else begin : g_accn
         assign acc_nxt = {s, acc[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         acc   <= '0;
         ar    <= '0;
         br    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ar    <= a;
                  br    <= b;
                  c     <= cin;
                  cnt   <= '0;
                  acc   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               ar  <= ar >> 1;
               br  <= br >> 1;
               c   <= co;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sum   <= acc_nxt;
                  cout  <= co;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule
